bitwise_logic_pipe: RTL and testbench

Parametrised, registered successor to the combinational multi-bit AND block. Computes one of eight bitwise operations on two DATA_WIDTH operands under a valid/ready handshake. A skid buffer gives full throughput with a registered ready. An optional chain mode feeds the previous result back as operand B, for running AND/OR/XOR reductions over a stream of words.

---
 rtl/bitwise_logic_pkg.sv | 31 +++
 rtl/bitwise_logic_pipe_skid_buf.sv | 57 +++++
 rtl/bitwise_logic_pipe.sv | 73 +++++++
 tb/tb_bitwise_logic_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bitwise_logic_pkg.sv
// Opcode encodings and the per-bit operation shared by the bitwise logic pipe.
package bitwise_logic_pkg;

    localparam int OP_BITS = 3;

    localparam logic [OP_BITS-1:0] OP_AND    = 3'd0;
    localparam logic [OP_BITS-1:0] OP_OR     = 3'd1;
    localparam logic [OP_BITS-1:0] OP_XOR    = 3'd2;
    localparam logic [OP_BITS-1:0] OP_NAND   = 3'd3;
    localparam logic [OP_BITS-1:0] OP_NOR    = 3'd4;
    localparam logic [OP_BITS-1:0] OP_XNOR   = 3'd5;
    localparam logic [OP_BITS-1:0] OP_ANDN   = 3'd6;
    localparam logic [OP_BITS-1:0] OP_PASS_A = 3'd7;

    // Single-bit kernel; applying it per bit gives the result for any width.
    function automatic logic op_bit(input logic [OP_BITS-1:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bitwise_logic_pipe_skid_buf.sv
// Two-entry valid/ready register slice: an output stage plus one skid entry,
// giving full throughput while in_ready comes straight from a flop.
module skid_buf #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             advance;
    logic             load_skid;

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    // The output stage may take new data when it is empty or emptying this cycle.
    assign advance   = ~out_valid | out_ready;
    assign load_skid = accept & ~advance;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
        end else if (advance) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= in_data;
                end
            end
        end else if (load_skid) begin
            skid_valid <= 1'b1;
        end
    end

    // NOTE: skid payload needs no reset; skid_valid alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data <= in_data;
        end
    end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Registered bitwise ALU with valid/ready handshake and an optional chained
// accumulator that can stand in for operand B.
module bitwise_logic_pipe
    import bitwise_logic_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int OP_WIDTH   = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic [OP_WIDTH-1:0]   op_in,
    input  logic                  chain_in,
    input  logic                  acc_clr_in,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  zero_out,
    output logic                  ones_out,
    output logic                  parity_out,
    output logic                  out_valid_out,
    input  logic                  out_ready_in
);

    localparam int PAYLOAD_W = DATA_WIDTH + 3;

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] eff_b;
    logic [DATA_WIDTH-1:0] result;
    logic [PAYLOAD_W-1:0]  in_payload;
    logic [PAYLOAD_W-1:0]  out_payload;
    logic                  accept;

    // A clear in the same cycle as a chained beat is seen by that beat as B=0.
    always_comb begin
        eff_b  = chain_in ? (acc_clr_in ? '0 : acc) : b_in;
        result = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            result[i] = op_bit(op_in, a_in[i], eff_b[i]);
        end
    end

    assign in_payload = {result, ~|result, &result, ^result};
    assign accept     = in_valid_in & in_ready_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc <= '0;
        end else if (accept) begin
            acc <= result;
        end else if (acc_clr_in) begin
            acc <= '0;
        end
    end

    skid_buf #(.WIDTH(PAYLOAD_W)) u_skid (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .in_valid  (in_valid_in),
        .in_ready  (in_ready_out),
        .in_data   (in_payload),
        .out_valid (out_valid_out),
        .out_ready (out_ready_in),
        .out_data  (out_payload)
    );

    assign y_out      = out_payload[PAYLOAD_W-1:3];
    assign zero_out   = out_payload[2];
    assign ones_out   = out_payload[1];
    assign parity_out = out_payload[0];

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed bench for bitwise_logic_pipe at DATA_WIDTH=8 with hand-computed expectations.
module tb_bitwise_logic_pipe;

    localparam int DW = 8;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [DW-1:0] a_in, b_in;
    logic [2:0]    op_in;
    logic          chain_in, acc_clr_in, in_valid_in, out_ready_in;
    logic          in_ready_out, zero_out, ones_out, parity_out, out_valid_out;
    logic [DW-1:0] y_out;

    int checks = 0;
    int errors = 0;

    bitwise_logic_pipe #(.DATA_WIDTH(DW), .OP_WIDTH(3)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .a_in          (a_in),
        .b_in          (b_in),
        .op_in         (op_in),
        .chain_in      (chain_in),
        .acc_clr_in    (acc_clr_in),
        .in_valid_in   (in_valid_in),
        .in_ready_out  (in_ready_out),
        .y_out         (y_out),
        .zero_out      (zero_out),
        .ones_out      (ones_out),
        .parity_out    (parity_out),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [DW-1:0] y, input logic v,
                             input logic z, input logic o, input logic p);
        check({tag, ".y"}, 32'(y_out), 32'(y));
        check({tag, ".valid"}, 32'(out_valid_out), 32'(v));
        check({tag, ".zero"}, 32'(zero_out), 32'(z));
        check({tag, ".ones"}, 32'(ones_out), 32'(o));
        check({tag, ".parity"}, 32'(parity_out), 32'(p));
    endtask

    // Inputs of a stalled beat must not change until it is accepted.
    logic          stall_q;
    logic [DW-1:0] a_q, b_q;
    logic [2:0]    op_q;
    logic          chain_q;
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                assert ({a_in, b_in, op_in, chain_in} === {a_q, b_q, op_q, chain_q}) else begin
                    errors++;
                    $error("FAIL stall_stable: observed %0h expected %0h",
                           {a_in, b_in, op_in, chain_in}, {a_q, b_q, op_q, chain_q});
                end
            end
            stall_q = in_valid_in && !in_ready_out;
            a_q = a_in; b_q = b_in; op_q = op_in; chain_q = chain_in;
        end
    end

    logic [DW-1:0] sweep_exp [8];

    initial begin
        sweep_exp = '{8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66, 8'h81, 8'hC3};
        rst_n_in = 1'b0;
        a_in = '0; b_in = '0; op_in = 3'd0;
        chain_in = 1'b0; acc_clr_in = 1'b0; in_valid_in = 1'b0; out_ready_in = 1'b1;
        #12;
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.in_ready", 32'(in_ready_out), 32'd1);
        rst_n_in = 1'b1;
        tick();

        // Opcode sweep at full throughput
        a_in = 8'hC3; b_in = 8'h5A; in_valid_in = 1'b1;
        for (int op = 0; op < 8; op++) begin
            op_in = 3'(op);
            tick();
            check_out($sformatf("sweep_op%0d", op), sweep_exp[op], 1'b1, 1'b0, 1'b0, 1'b0);
        end
        in_valid_in = 1'b0;
        tick();
        check("sweep.drained", 32'(out_valid_out), 32'd0);

        // Back-pressure: stream 4 beats with out_ready low for 3 cycles
        op_in = 3'd7; b_in = 8'h00; out_ready_in = 1'b0;
        in_valid_in = 1'b1; a_in = 8'h11;
        tick();
        check("bp1.y", 32'(y_out), 32'h11);
        check("bp1.in_ready", 32'(in_ready_out), 32'd1);
        a_in = 8'h22;
        tick();
        check("bp2.y", 32'(y_out), 32'h11);
        check("bp2.in_ready", 32'(in_ready_out), 32'd0);
        a_in = 8'h33;
        tick();
        check("bp3.y", 32'(y_out), 32'h11);
        check("bp3.in_ready", 32'(in_ready_out), 32'd0);
        out_ready_in = 1'b1;
        tick();
        check("bp_drain.y", 32'(y_out), 32'h22);
        check("bp_drain.valid", 32'(out_valid_out), 32'd1);
        check("bp_drain.in_ready", 32'(in_ready_out), 32'd1);
        tick();
        check("bp_beat3.y", 32'(y_out), 32'h33);
        a_in = 8'h44;
        tick();
        check("bp_beat4.y", 32'(y_out), 32'h44);
        in_valid_in = 1'b0;
        tick();
        check("bp.drained", 32'(out_valid_out), 32'd0);

        // Chained XOR running reduction, cleared on the first beat
        op_in = 3'd2; chain_in = 1'b1; b_in = 8'hFF; in_valid_in = 1'b1;
        acc_clr_in = 1'b1; a_in = 8'h01;
        tick();
        check("xor1.y", 32'(y_out), 32'h01);
        acc_clr_in = 1'b0; a_in = 8'h02;
        tick();
        check("xor2.y", 32'(y_out), 32'h03);
        a_in = 8'h04;
        tick();
        check("xor3.y", 32'(y_out), 32'h07);
        a_in = 8'h08;
        tick();
        check_out("xor4", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

        // Chained AND with a same-cycle clear
        op_in = 3'd0; a_in = 8'hFF; acc_clr_in = 1'b1;
        tick();
        check_out("and_clr", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        acc_clr_in = 1'b0;
        tick();
        check_out("and_next", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        in_valid_in = 1'b0; chain_in = 1'b0;
        tick();

        // Output stall hold with NOR
        op_in = 3'd4; a_in = 8'h00; b_in = 8'h00; out_ready_in = 1'b0; in_valid_in = 1'b1;
        tick();
        in_valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_out($sformatf("nor_hold%0d", i), 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        out_ready_in = 1'b1;
        tick();
        check("nor.drained", 32'(out_valid_out), 32'd0);

        // Asynchronous reset with the skid full
        op_in = 3'd2; chain_in = 1'b1; out_ready_in = 1'b0; in_valid_in = 1'b1;
        acc_clr_in = 1'b1; a_in = 8'h05;
        tick();
        acc_clr_in = 1'b0; a_in = 8'h0A;
        tick();
        in_valid_in = 1'b0;
        check("rst_pre.in_ready", 32'(in_ready_out), 32'd0);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_out("rst_async", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_async.in_ready", 32'(in_ready_out), 32'd1);
        #3;
        rst_n_in = 1'b1;
        op_in = 3'd1; a_in = 8'h10; out_ready_in = 1'b1; in_valid_in = 1'b1;
        tick();
        check_out("post_rst", 8'h10, 1'b1, 1'b0, 1'b0, 1'b1);
        in_valid_in = 1'b0; chain_in = 1'b0;
        tick();
        check("post_rst.drained", 32'(out_valid_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
